// File: rtl/demux_fifo_2lane.sv
// demux_fifo_2lane: splits an interleaved stream into two first-word-fall-through lane FIFOs.
// Define DEMUX_ALMOST_FULL_EN to add the almost_full_0/almost_full_1 outputs.
module demux_fifo_2lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop_0,
    input  logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_out_0,
    output logic                  valid_out_1,
    output logic                  full_0,
    output logic                  full_1,
    output logic                  overflow_err
`ifdef DEMUX_ALMOST_FULL_EN
    ,
    output logic                  almost_full_0,
    output logic                  almost_full_1
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
        $error("demux_fifo_2lane: illegal DEPTH/AF_THRESH");
    end

    logic                       sel_q, ovf_q;
    logic [1:0]                 pop, push, do_pop, full, nonempty, af;
    logic [1:0][DATA_WIDTH-1:0] dout;

    assign pop = {pop_1, pop_0};

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]         wptr_q, rptr_q;
        logic [AW:0]           cnt_q, cnt_d;
        assign full[l]     = cnt_q == FULL_CNT;
        assign nonempty[l] = cnt_q != '0;
        // a full lane still accepts the word when its head leaves in the same cycle
        assign push[l]     = valid_in && (sel_q == 1'(l)) && (!full[l] || pop[l]);
        assign do_pop[l]   = pop[l] && nonempty[l];
        assign cnt_d       = cnt_q + {{AW{1'b0}}, push[l]} - {{AW{1'b0}}, do_pop[l]};
        assign dout[l]     = nonempty[l] ? mem_q[rptr_q] : '0;
`ifdef DEMUX_ALMOST_FULL_EN
        assign af[l]       = cnt_q >= (AW+1)'(AF_THRESH);
`else
        assign af[l]       = 1'b0;
`endif
        always_ff @(posedge clk) begin
            if (!reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[l]) wptr_q <= wptr_q + 1'b1;
                if (do_pop[l]) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end
        always_ff @(posedge clk) begin
            if (reset && push[l]) mem_q[wptr_q] <= data_in;
        end
    end

    // sel advances on every offered word, stored or dropped, to keep lanes aligned
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (valid_in) sel_q <= ~sel_q;
            if (valid_in && full[sel_q] && !pop[sel_q]) ovf_q <= 1'b1;
        end
    end

    assign data_out_0   = dout[0];
    assign data_out_1   = dout[1];
    assign valid_out_0  = nonempty[0];
    assign valid_out_1  = nonempty[1];
    assign full_0       = full[0];
    assign full_1       = full[1];
    assign overflow_err = ovf_q;
`ifdef DEMUX_ALMOST_FULL_EN
    assign almost_full_0 = af[0];
    assign almost_full_1 = af[1];
`else
    logic unused_af;
    assign unused_af = ^af;
`endif
endmodule

// File: tb/tb_demux_fifo_2lane.sv
// tb_demux_fifo_2lane: vector table, corner sequences and random traffic against a queue model.
module tb_demux_fifo_2lane;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic       clk = 1'b0, reset = 1'b0, valid_in = 1'b0, pop_0 = 1'b0, pop_1 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, full_0, full_1, overflow_err;
`ifdef DEMUX_ALMOST_FULL_EN
    logic       almost_full_0, almost_full_1;
`endif

    demux_fifo_2lane #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
        .full_0(full_0), .full_1(full_1), .overflow_err(overflow_err)
`ifdef DEMUX_ALMOST_FULL_EN
        , .almost_full_0(almost_full_0), .almost_full_1(almost_full_1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] q0[$], q1[$];
    bit m_sel, m_ovf;

    typedef struct {
        logic [3:0] in;
        logic [7:0] d;
        logic [7:0] e0, e1;
        logic [4:0] ef;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [7:0] d, input bit p0, input bit p1);
        bit e0, e1, tfull, tpop;
        if (!r) begin
            q0.delete();
            q1.delete();
            m_sel = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        e0    = p0 && q0.size() > 0;
        e1    = p1 && q1.size() > 0;
        tfull = m_sel ? q1.size() == DEPTH : q0.size() == DEPTH;
        tpop  = m_sel ? p1 : p0;
        if (e0) void'(q0.pop_front());
        if (e1) void'(q1.pop_front());
        if (v) begin
            if (tfull && !tpop) m_ovf = 1'b1;
            else if (m_sel) q1.push_back(d);
            else q0.push_back(d);
            m_sel = !m_sel;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit p0, input bit p1);
        logic [7:0] x0, x1;
        reset = r; valid_in = v; data_in = d; pop_0 = p0; pop_1 = p1;
        @(posedge clk);
        model(r, v, d, p0, p1);
        #1;
        x0 = q0.size() > 0 ? q0[0] : 8'h00;
        x1 = q1.size() > 0 ? q1[0] : 8'h00;
        chk("m_d0", data_out_0, x0);
        chk("m_d1", data_out_1, x1);
        chk("m_v0", valid_out_0, q0.size() > 0);
        chk("m_v1", valid_out_1, q1.size() > 0);
        chk("m_f0", full_0, q0.size() == DEPTH);
        chk("m_f1", full_1, q1.size() == DEPTH);
        chk("m_ovf", overflow_err, m_ovf);
`ifdef DEMUX_ALMOST_FULL_EN
        chk("m_af0", almost_full_0, q0.size() >= AF);
        chk("m_af1", almost_full_1, q1.size() >= AF);
`endif
    endtask

    function automatic vec_t mk(logic [3:0] in, logic [7:0] d, logic [7:0] e0, logic [7:0] e1, logic [4:0] ef);
        vec_t t;
        t.in = in; t.d = d; t.e0 = e0; t.e1 = e1; t.ef = ef;
        return t;
    endfunction

    initial begin
        // in = {reset_n, valid, pop_0, pop_1}; ef = {valid_out_0, valid_out_1, full_0, full_1, overflow_err}
        tbl[0]  = mk(4'b0100, 8'h55, 8'h00, 8'h00, 5'b00000);
        tbl[1]  = mk(4'b1100, 8'h11, 8'h11, 8'h00, 5'b10000);
        tbl[2]  = mk(4'b1100, 8'hFF, 8'h11, 8'hFF, 5'b11000);
        tbl[3]  = mk(4'b1100, 8'h12, 8'h11, 8'hFF, 5'b11000);
        tbl[4]  = mk(4'b1100, 8'hFE, 8'h11, 8'hFF, 5'b11000);
        tbl[5]  = mk(4'b1100, 8'h13, 8'h11, 8'hFF, 5'b11000);
        tbl[6]  = mk(4'b1100, 8'h14, 8'h11, 8'hFF, 5'b11000);
        tbl[7]  = mk(4'b1100, 8'h15, 8'h11, 8'hFF, 5'b11100);
        tbl[8]  = mk(4'b1100, 8'h16, 8'h11, 8'hFF, 5'b11110);
        tbl[9]  = mk(4'b1100, 8'h19, 8'h11, 8'hFF, 5'b11111);
        tbl[10] = mk(4'b1100, 8'h1A, 8'h11, 8'hFF, 5'b11111);
        tbl[11] = mk(4'b1110, 8'h20, 8'h12, 8'hFF, 5'b11111);
        tbl[12] = mk(4'b1001, 8'h00, 8'h12, 8'hFE, 5'b11101);
        tbl[13] = mk(4'b0100, 8'h55, 8'h00, 8'h00, 5'b00000);
        tbl[14] = mk(4'b1100, 8'h13, 8'h13, 8'h00, 5'b10000);
        tbl[15] = mk(4'b1001, 8'h00, 8'h13, 8'h00, 5'b10000);
        tbl[16] = mk(4'b1110, 8'h21, 8'h00, 8'h21, 5'b01000);
        tbl[17] = mk(4'b1110, 8'h22, 8'h22, 8'h21, 5'b11000);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].in[3], tbl[i].in[2], tbl[i].d, tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("t%0d_d0", i), data_out_0, tbl[i].e0);
            chk($sformatf("t%0d_d1", i), data_out_1, tbl[i].e1);
            chk($sformatf("t%0d_flags", i),
                {valid_out_0, valid_out_1, full_0, full_1, overflow_err}, tbl[i].ef);
        end

        // full lane 0 with simultaneous push and pop: no drop, stays full
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        chk("fill_f0", full_0, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
        chk("pushpop_ovf", overflow_err, 1'b0);
        chk("pushpop_f0", full_0, 1'b1);
        chk("pushpop_d0", data_out_0, 8'h13);

        // pop_1 held on empty lane 1: no effect, no error
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("emptypop_v1", valid_out_1, 1'b0);
        chk("emptypop_d1", data_out_1, 8'h00);
        chk("emptypop_ovf", overflow_err, 1'b0);
        step(1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
        chk("emptypop_cnt", data_out_1, 8'h41);

`ifdef DEMUX_ALMOST_FULL_EN
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
        chk("af0_two", almost_full_0, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b0, 1'b0);
        chk("af0_three", almost_full_0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("af0_pop", almost_full_0, 1'b0);
`endif

        // random traffic, occasional mid-stream reset
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux_fifo_2lane.md
# demux_fifo_2lane

Downstream stage of the 2:1 lane mux: consumes the interleaved 8-bit stream (`data_out_c`/`valid_out_c`) and separates it back into lane 0 and lane 1. Each word is steered by a toggling lane selector into a per-lane first-word-fall-through FIFO, drained independently by the consumer through `pop` strobes. Overflow is flagged, never silent.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width.
- `DEPTH`, 4: entries per lane FIFO; power of two, ≥ 2.
- `AF_THRESH`, 3: almost-full level (used only with `DEMUX_ALMOST_FULL_EN`); 1 ≤ AF_THRESH ≤ DEPTH.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `data_in`  in  DATA_WIDTH  interleaved word from the mux.
- `valid_in`  in  1  `data_in` carries a word this cycle.
- `pop_0`, `pop_1`  in  1  consumer removes head of lane 0 / lane 1.
- `data_out_0`, `data_out_1`  out  DATA_WIDTH  head word of lane; 0 when lane empty.
- `valid_out_0`, `valid_out_1`  out  1  lane FIFO non-empty.
- `full_0`, `full_1`  out  1  lane count == DEPTH.
- `overflow_err`  out  1  sticky: a word was dropped.
- `almost_full_0`, `almost_full_1`  out  1  count ≥ AF_THRESH (present only with macro).

## Operation
- Lane selector `sel` (1 bit): 0 after reset; toggles on every cycle with `valid_in`=1, whether or not the word is stored, so lane alignment is preserved after a drop.
- Push: `valid_in`=1 writes `data_in` into FIFO[`sel`] when that lane is not full, or when full and the same lane's pop is asserted that cycle.
- Drop: `valid_in`=1, target lane full, no pop on that lane → word discarded, `overflow_err` set to 1 until reset; other lane unaffected.
- Pop: `pop_x`=1 with `valid_out_x`=1 advances the read pointer; `pop_x` on empty lane is ignored (no underflow, no error).
- Per lane: read/write pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits; simultaneous push+pop on the same lane leaves count unchanged.
- Storage is not cleared by reset; only pointers, counts, `sel`, `overflow_err` are.

## Timing
- Reset (`reset`=0 at an edge): next cycle all outputs 0 (`data_out_x`=0, `valid_out_x`=0, `full_x`=0, `overflow_err`=0, `almost_full_x`=0); `sel`=0. Reset mid-stream discards all queued words; a `valid_in` in the reset cycle is ignored and does not toggle `sel`.
- Write latency: word accepted at edge k appears on `data_out_x` with `valid_out_x`=1 after edge k (1 cycle) if the lane was empty; otherwise behind older words.
- Pop is combinationally qualified; head updates after the popping edge. Back-to-back pops drain one word per cycle.
- `full_x`, `valid_out_x`, `almost_full_x` are derived from registered counts; no combinational path from `valid_in` or `pop_x` to any output.
- Empty lane with push and pop same cycle: pop ignored, push stored, count 0→1.
- Full lane with push and pop same cycle: both happen, no error, stays full.

## Configuration
- `DEMUX_ALMOST_FULL_EN` defined: `almost_full_0`/`almost_full_1` ports exist and assert while lane count ≥ AF_THRESH, registered, reset 0.
- Not defined: those ports and their compare logic are absent; all other behaviour identical.

## Test plan
- Reset then stream 0x11,0xFF,0x12,0xFE with `valid_in`=1, no pops → lane 0 holds 0x11,0x12; lane 1 holds 0xFF,0xFE; `data_out_0`=0x11, `data_out_1`=0xFF one cycle after first write.
- With DEPTH=4, send 10 words 0x11..0x1A, no pops → both `full_x`=1 after 8th word; 9th (0x19) and 10th (0x1A) dropped; `overflow_err`=1 and stays 1; `sel` back to 0.
- Fill lane 0 to 4, then on the cycle lane 0 receives 0x20 assert `pop_0` → head 0x11 removed, 0x20 stored, `full_0` stays 1, `overflow_err`=0.
- `pop_1` held high on empty lane 1 for 3 cycles → `valid_out_1`=0, `data_out_1`=0, count stays 0, no error.
- Store 3 words, drop `reset` to 0 for one cycle mid-stream with `valid_in`=1 → all outputs 0, next word 0x13 lands in lane 0.
- With `DEMUX_ALMOST_FULL_EN`, AF_THRESH=3: 3rd word into lane 0 → `almost_full_0`=1 after that edge; one `pop_0` → 0.
